// File: rtl/cache_arbiter.sv
// cache_arbiter: shares the single line-wide memory port between the I-cache
// and the D-cache. One request is granted at a time. The winning address, op and
// writeback data are latched, the memory port is driven until mem_resp, and the
// line is returned with a one-cycle resp pulse. Ties go to the side not served last.
module cache_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp,
    output logic [1:0]            grant
);

    // state | meaning
    // IDLE  | sample cache requests, pick a winner
    // MEM   | memory port driven from latched request, wait for mem_resp
    // RESP  | one-cycle resp pulse to the granted cache
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MEM  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]            state_q, state_d;
    logic                  last_d_q, last_d_d;   // 1: D-cache was served last
    logic [1:0]            grant_q, grant_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LINE_WIDTH-1:0] wdata_q, wdata_d;
    logic [LINE_WIDTH-1:0] line_q, line_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;
    logic                  i_resp_q, i_resp_d;
    logic                  d_resp_q, d_resp_d;

    logic i_pend, d_pend, pick_i, pick_d;

    // Round-robin choice: I wins when it is alone or when D was served last.
    always_comb begin
        i_pend = i_read;
        d_pend = d_read | d_write;
        pick_i = i_pend & (~d_pend | last_d_q);
        pick_d = d_pend & ~pick_i;
    end

    // Next-state and datapath update for the arbitration sequence.
    always_comb begin
        state_d     = state_q;
        last_d_d    = last_d_q;
        grant_d     = grant_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        line_d      = line_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        i_resp_d    = 1'b0;
        d_resp_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_i) begin
                    grant_d     = 2'b01;
                    addr_d      = i_address;
                    wdata_d     = '0;
                    last_d_d    = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_write_d = 1'b0;
                    state_d     = ST_MEM;
                end else if (pick_d) begin
                    // A simultaneous read and write from the D-cache is a writeback.
                    grant_d     = 2'b10;
                    addr_d      = d_address;
                    wdata_d     = d_wdata;
                    last_d_d    = 1'b1;
                    mem_read_d  = ~d_write;
                    mem_write_d = d_write;
                    state_d     = ST_MEM;
                end
            end
            ST_MEM: begin
                if (mem_resp) begin
                    if (!mem_write_q) begin
                        line_d = mem_rdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    i_resp_d    = grant_q[0];
                    d_resp_d    = grant_q[1];
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_d = 2'b00;
                state_d = ST_IDLE;
            end
            default: begin
                grant_d     = 2'b00;
                mem_read_d  = 1'b0;
                mem_write_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves last_grant at D so I wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_d_q    <= 1'b1;
            grant_q     <= 2'b00;
            addr_q      <= '0;
            wdata_q     <= '0;
            line_q      <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            i_resp_q    <= 1'b0;
            d_resp_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_d_q    <= last_d_d;
            grant_q     <= grant_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            line_q      <= line_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            i_resp_q    <= i_resp_d;
            d_resp_q    <= d_resp_d;
        end
    end

    // Both caches see the same line register; only the side with resp high uses it.
    always_comb begin
        i_rdata     = line_q;
        d_rdata     = line_q;
        i_resp      = i_resp_q;
        d_resp      = d_resp_q;
        mem_read    = mem_read_q;
        mem_write   = mem_write_q;
        mem_address = addr_q;
        mem_wdata   = wdata_q;
        grant       = grant_q;
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Testbench for cache_arbiter: cache requesters and a memory responder driven from
// tasks, expected grants/ops/data from a round-robin model of the arbitration rules.
module tb_cache_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write, mem_resp;
    logic [AW-1:0] i_address, d_address;
    logic [LW-1:0] d_wdata, mem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, mem_wdata;
    logic          i_resp, d_resp, mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [1:0]    grant;

    cache_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int model_last;   // side served last: 0 = I, 1 = D

    // Observations of the most recent memory transaction.
    logic          r_saw, r_rd, r_wr, r_iresp, r_dresp, r_opresp;
    logic [AW-1:0] r_addr;
    logic [LW-1:0] r_wdata, r_irdata, r_drdata;
    logic [1:0]    r_grant;
    int            r_unst, r_turn;

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Memory side: wait for a request, hold it for the given latency, answer with exp_line.
    // Ends at the falling edge inside the RESP cycle.
    task automatic mem_txn(input int latency, input int scramble, input logic [LW-1:0] exp_line);
        r_saw = 0; r_turn = 0; r_unst = 0;
        r_rd = 0; r_wr = 0; r_addr = '0; r_wdata = '0; r_grant = '0;
        r_iresp = 0; r_dresp = 0; r_irdata = '0; r_drdata = '0; r_opresp = 0;
        for (int k = 0; k < 20 && !r_saw; k++) begin
            @(negedge clk);
            r_turn++;
            if (mem_read || mem_write) r_saw = 1;
        end
        if (!r_saw) return;
        r_rd = mem_read; r_wr = mem_write; r_addr = mem_address;
        r_wdata = mem_wdata; r_grant = grant;
        if (mem_read && mem_write) r_unst++;
        for (int k = 0; k < latency; k++) begin
            if (scramble == 1) i_address = $urandom;
            if (scramble == 2) begin
                d_address = $urandom;
                d_wdata = rand_line();
            end
            @(negedge clk);
            if (mem_read !== r_rd || mem_write !== r_wr || mem_address !== r_addr ||
                mem_wdata !== r_wdata || grant !== r_grant || (mem_read && mem_write) ||
                i_resp || d_resp) r_unst++;
        end
        mem_resp = 1'b1;
        mem_rdata = exp_line;
        @(negedge clk);
        mem_resp = 1'b0;
        mem_rdata = rand_line();
        r_iresp = i_resp; r_dresp = d_resp;
        r_irdata = i_rdata; r_drdata = d_rdata;
        r_opresp = mem_read | mem_write;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_read = 0; d_read = 0; d_write = 0; mem_resp = 0;
        i_address = '0; d_address = '0; d_wdata = '0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp, grant} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {mem_read, mem_write, i_resp, d_resp, grant});
        end
        checks++;
        if (mem_address !== '0 || mem_wdata !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h irdata %h drdata %h want 0",
                     mem_address, mem_wdata, i_rdata, d_rdata);
        end
        rst = 1'b0;
        model_last = 1;
        @(negedge clk);
    endtask

    task automatic test_i_read();
        logic [LW-1:0] pat;
        pat = {(LW / 8){8'hA5}};
        i_read = 1; i_address = 32'h0000_0060;
        mem_txn(4, 0, pat);
        checks++;
        if (!r_saw || r_turn != 1) begin
            errors++;
            $display("FAIL i_read_start: saw %0d turn %0d want 1 1", r_saw, r_turn);
        end
        checks++;
        if ({r_rd, r_wr, r_grant, r_addr} !== {1'b1, 1'b0, 2'b01, 32'h60}) begin
            errors++;
            $display("FAIL i_read_port: rd %b wr %b grant %b addr %h want 1 0 01 00000060",
                     r_rd, r_wr, r_grant, r_addr);
        end
        checks++;
        if (r_unst != 0) begin
            errors++;
            $display("FAIL i_read_hold: unstable %0d want 0", r_unst);
        end
        checks++;
        if ({r_iresp, r_dresp, r_opresp} !== 3'b100 || r_irdata !== pat) begin
            errors++;
            $display("FAIL i_read_resp: iresp %b dresp %b op %b rdata %h want 1 0 0 %h",
                     r_iresp, r_dresp, r_opresp, r_irdata, pat);
        end
        model_last = 0;
        i_read = 0;
        @(negedge clk);
        checks++;
        if ({i_resp, d_resp, grant, mem_read, mem_write} !== 6'b0) begin
            errors++;
            $display("FAIL i_read_idle: got %b want 000000", {i_resp, d_resp, grant, mem_read, mem_write});
        end
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wd;
        wd = {(LW / 32){32'h1234_5678}};
        d_write = 1; d_address = 32'h0000_1000; d_wdata = wd;
        mem_txn($urandom_range(0, 5), 0, rand_line());
        checks++;
        if (!r_saw || {r_rd, r_wr, r_grant, r_addr} !== {1'b0, 1'b1, 2'b10, 32'h1000}) begin
            errors++;
            $display("FAIL d_write_port: saw %b rd %b wr %b grant %b addr %h want 1 0 1 10 00001000",
                     r_saw, r_rd, r_wr, r_grant, r_addr);
        end
        checks++;
        if (r_wdata !== wd || r_unst != 0) begin
            errors++;
            $display("FAIL d_write_data: wdata %h unstable %0d want %h 0", r_wdata, r_unst, wd);
        end
        checks++;
        if ({r_iresp, r_dresp, r_opresp} !== 3'b010) begin
            errors++;
            $display("FAIL d_write_resp: got %b want 010", {r_iresp, r_dresp, r_opresp});
        end
        model_last = 1;
        d_write = 0;
        @(negedge clk);
        checks++;
        if ({i_resp, d_resp, grant} !== 4'b0) begin
            errors++;
            $display("FAIL d_write_idle: got %b want 0000", {i_resp, d_resp, grant});
        end
    endtask

    task automatic test_rw_both();
        d_read = 1; d_write = 1; d_address = $urandom; d_wdata = rand_line();
        mem_txn(2, 0, rand_line());
        checks++;
        if (!r_saw || {r_rd, r_wr, r_grant, r_dresp} !== 5'b01101 || r_wdata !== d_wdata) begin
            errors++;
            $display("FAIL rw_both: saw %b rd %b wr %b grant %b dresp %b want 1 0 1 10 1",
                     r_saw, r_rd, r_wr, r_grant, r_dresp);
        end
        model_last = 1;
        d_read = 0; d_write = 0;
        @(negedge clk);
    endtask

    // Random request patterns; with both_always both caches keep requesting (alternation).
    task automatic test_stream(input int n, input bit both_always);
        logic          pi, pd, win_i, exp_wr;
        int            dop;
        logic [AW-1:0] ia, da, exp_addr;
        logic [LW-1:0] dw, exp_line;
        pi = 1; pd = both_always ? 1'b1 : 1'($urandom_range(0, 1));
        dop = $urandom_range(0, 2); ia = $urandom; da = $urandom; dw = rand_line();
        for (int it = 0; it < n; it++) begin
            i_read = pi; i_address = ia;
            d_read = pd && dop != 1; d_write = pd && dop != 0;
            d_address = da; d_wdata = dw;
            win_i = pi && (!pd || model_last == 1);
            exp_wr = !win_i && dop != 0;
            exp_addr = win_i ? ia : da;
            exp_line = rand_line();
            mem_txn($urandom_range(0, 4), 0, exp_line);
            checks++;
            if (!r_saw || r_turn != 1) begin
                errors++;
                $display("FAIL stream_turn[%0d]: saw %b turn %0d want 1 1", it, r_saw, r_turn);
            end
            checks++;
            if ({r_grant, r_rd, r_wr, r_addr} !== {win_i ? 2'b01 : 2'b10, !exp_wr, exp_wr, exp_addr}) begin
                errors++;
                $display("FAIL stream_grant[%0d]: grant %b rd %b wr %b addr %h want %b %b %b %h",
                         it, r_grant, r_rd, r_wr, r_addr, win_i ? 2'b01 : 2'b10, !exp_wr, exp_wr, exp_addr);
            end
            if (exp_wr) begin
                checks++;
                if (r_wdata !== dw) begin
                    errors++;
                    $display("FAIL stream_wdata[%0d]: got %h want %h", it, r_wdata, dw);
                end
            end
            checks++;
            if ({r_iresp, r_dresp, r_opresp} !== {win_i, !win_i, 1'b0} || r_unst != 0) begin
                errors++;
                $display("FAIL stream_resp[%0d]: iresp %b dresp %b op %b unstable %0d want %b %b 0 0",
                         it, r_iresp, r_dresp, r_opresp, r_unst, win_i, !win_i);
            end
            if (!exp_wr) begin
                checks++;
                if ((win_i ? r_irdata : r_drdata) !== exp_line) begin
                    errors++;
                    $display("FAIL stream_rdata[%0d]: got %h want %h", it,
                             win_i ? r_irdata : r_drdata, exp_line);
                end
            end
            model_last = win_i ? 0 : 1;
            if (win_i) begin
                pi = both_always ? 1'b1 : 1'($urandom_range(0, 1));
                ia = $urandom;
            end else begin
                pd = both_always ? 1'b1 : 1'($urandom_range(0, 1));
                dop = $urandom_range(0, 2); da = $urandom; dw = rand_line();
            end
            if (!pi && !pd) begin
                if ($urandom_range(0, 1) == 1) pi = 1; else pd = 1;
            end
            if (it == n - 1) begin
                pi = 0; pd = 0;
            end
            i_read = pi; i_address = ia;
            d_read = pd && dop != 1; d_write = pd && dop != 0;
            d_address = da; d_wdata = dw;
            @(negedge clk);
            checks++;
            if ({i_resp, d_resp, grant, mem_read, mem_write} !== 6'b0) begin
                errors++;
                $display("FAIL stream_idle[%0d]: got %b want 000000", it,
                         {i_resp, d_resp, grant, mem_read, mem_write});
            end
        end
    endtask

    task automatic test_first_tie();
        logic [AW-1:0] ia, da;
        logic [LW-1:0] exp_line;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        ia = $urandom; da = $urandom;
        i_read = 1; i_address = ia; d_read = 1; d_address = da;
        mem_txn(1, 0, rand_line());
        checks++;
        if ({r_grant, r_addr, r_iresp} !== {2'b01, ia, 1'b1}) begin
            errors++;
            $display("FAIL tie_first: grant %b addr %h iresp %b want 01 %h 1", r_grant, r_addr, r_iresp, ia);
        end
        i_read = 0;
        exp_line = rand_line();
        mem_txn(0, 0, exp_line);
        checks++;
        if ({r_grant, r_addr, r_dresp, r_iresp} !== {2'b10, da, 1'b1, 1'b0} || r_drdata !== exp_line) begin
            errors++;
            $display("FAIL tie_second: grant %b addr %h dresp %b iresp %b rdata %h want 10 %h 1 0 %h",
                     r_grant, r_addr, r_dresp, r_iresp, r_drdata, da, exp_line);
        end
        model_last = 1;
        d_read = 0;
        @(negedge clk);
    endtask

    task automatic test_latch_stable();
        logic [AW-1:0] a;
        logic [LW-1:0] wd;
        a = $urandom;
        i_read = 1; i_address = a;
        mem_txn(5, 2, rand_line());
        checks++;
        if (r_unst != 0 || r_addr !== a || r_grant !== 2'b01) begin
            errors++;
            $display("FAIL latch_i: unstable %0d addr %h grant %b want 0 %h 01", r_unst, r_addr, r_grant, a);
        end
        i_read = 0;
        @(negedge clk);
        a = $urandom; wd = rand_line();
        d_write = 1; d_address = a; d_wdata = wd;
        mem_txn(5, 1, rand_line());
        checks++;
        if (r_unst != 0 || r_addr !== a || r_wdata !== wd || r_wr !== 1'b1) begin
            errors++;
            $display("FAIL latch_d: unstable %0d addr %h wr %b want 0 %h 1", r_unst, r_addr, r_wr, a);
        end
        model_last = 1;
        d_write = 0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_mem();
        logic [AW-1:0] ia, da;
        i_read = 1; i_address = $urandom;
        mem_txn(1, 0, rand_line());
        i_read = 0;
        model_last = 0;
        @(negedge clk);
        i_read = 1; i_address = $urandom;
        @(negedge clk);
        checks++;
        if (mem_read !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: mem_read %b want 1", mem_read);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mem_read, mem_write, i_resp, d_resp, grant} !== 6'b0 || mem_address !== '0 ||
            mem_wdata !== '0 || i_rdata !== '0) begin
            errors++;
            $display("FAIL rst_mid_async: ctrl %b addr %h want 000000 0",
                     {mem_read, mem_write, i_resp, d_resp, grant}, mem_address);
        end
        i_read = 0;
        @(negedge clk);
        rst = 1'b0;
        model_last = 1;
        ia = $urandom; da = $urandom;
        i_read = 1; i_address = ia; d_read = 1; d_address = da;
        mem_txn(2, 0, rand_line());
        checks++;
        if (!r_saw || {r_grant, r_addr, r_iresp} !== {2'b01, ia, 1'b1}) begin
            errors++;
            $display("FAIL rst_mid_after: saw %b grant %b addr %h iresp %b want 1 01 %h 1",
                     r_saw, r_grant, r_addr, r_iresp, ia);
        end
        i_read = 0; d_read = 0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_rw_both();
        test_first_tie();
        test_stream(6, 1'b1);
        test_stream(40, 1'b0);
        test_latch_stable();
        test_reset_mid_mem();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
